// File: rtl/ycconfig_pkg.sv
// Shared encodings for the Morphle yellow-cell configuration logic:
// symbol codes, FSM states and decoded flag bit positions.
package ycconfig_pkg;

    localparam logic [2:0] SYM_SPACE = 3'd0;
    localparam logic [2:0] SYM_PLUS  = 3'd1;
    localparam logic [2:0] SYM_MINUS = 3'd2;
    localparam logic [2:0] SYM_BAR   = 3'd3;
    localparam logic [2:0] SYM_ONE   = 3'd4;
    localparam logic [2:0] SYM_ZERO  = 3'd5;
    localparam logic [2:0] SYM_Y     = 3'd6;
    localparam logic [2:0] SYM_N     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    localparam int NFLAGS    = 9;
    localparam int F_EMPTY   = 0;
    localparam int F_HBLOCK  = 1;
    localparam int F_HBYPASS = 2;
    localparam int F_HMATCH0 = 3;
    localparam int F_HMATCH1 = 4;
    localparam int F_VBLOCK  = 5;
    localparam int F_VBYPASS = 6;
    localparam int F_VMATCH0 = 7;
    localparam int F_VMATCH1 = 8;

    typedef logic [NFLAGS-1:0] flags_t;

endpackage

// File: rtl/ycconfig_decode.sv
// Single-cell decode of a 3-bit yellow-cell symbol into its nine flags.
// Shared by the row loader and the single-cell configuration block.
module ycconfig_decode
    import ycconfig_pkg::*;
(
    input  logic [2:0] code,
    output flags_t     flags
);

    always_comb begin
        flags = '0;
        case (code)
            SYM_SPACE: begin
                flags[F_EMPTY]  = 1'b1;
                flags[F_HBLOCK] = 1'b1;
                flags[F_VBLOCK] = 1'b1;
            end
            SYM_PLUS: begin
                flags[F_HBYPASS] = 1'b1;
                flags[F_VBYPASS] = 1'b1;
            end
            SYM_MINUS: begin
                flags[F_HBYPASS] = 1'b1;
                flags[F_VBLOCK]  = 1'b1;
            end
            SYM_BAR: begin
                flags[F_HBLOCK]  = 1'b1;
                flags[F_VBYPASS] = 1'b1;
            end
            SYM_ONE: begin
                flags[F_HMATCH1] = 1'b1;
                flags[F_VMATCH1] = 1'b1;
            end
            SYM_ZERO: begin
                flags[F_HMATCH0] = 1'b1;
                flags[F_VMATCH0] = 1'b1;
            end
            SYM_N: begin
                flags[F_HMATCH0] = 1'b1;
                flags[F_HMATCH1] = 1'b1;
                flags[F_VMATCH0] = 1'b1;
                flags[F_VMATCH1] = 1'b1;
            end
            default: flags = '0;  // 'Y' drives nothing
        endcase
    end

endmodule

// File: rtl/ycconfig_row.sv
// Row loader: host symbols are serialised MSB-first into a shadow chain and
// committed atomically to the active config once a full row has arrived.
module ycconfig_row
    import ycconfig_pkg::*;
#(
    parameter int CELLS = 8,
    parameter int SBITS = 3
) (
    input  logic             confclk,
    input  logic             reset,
    input  logic             sym_valid,
    input  logic [SBITS-1:0] sym_data,
    output logic             sym_ready,
    output logic             busy,
    output logic             done,
    output logic             cbitout,
    output logic [CELLS-1:0] empty,
    output logic [CELLS-1:0] hblock,
    output logic [CELLS-1:0] hbypass,
    output logic [CELLS-1:0] hmatch0,
    output logic [CELLS-1:0] hmatch1,
    output logic [CELLS-1:0] vblock,
    output logic [CELLS-1:0] vbypass,
    output logic [CELLS-1:0] vmatch0,
    output logic [CELLS-1:0] vmatch1
);

    localparam int W  = SBITS * CELLS;
    localparam int CW = $clog2(CELLS + 1);

    state_t           state, nstate;
    logic [W-1:0]     shadow, active;
    logic [SBITS-1:0] hold;
    logic [1:0]       bitcnt;
    logic [CW-1:0]    symcnt;

    always_ff @(posedge confclk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:  if (sym_valid) nstate = ST_SHIFT;
            ST_SHIFT: if (bitcnt == 2'd0)
                          nstate = (symcnt == CW'(CELLS - 1)) ? ST_APPLY : ST_IDLE;
            ST_APPLY: nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        sym_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE:  begin sym_ready = 1'b1; busy = 1'b0; end
            ST_APPLY: done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge confclk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
            hold   <= '0;
            bitcnt <= '0;
            symcnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (sym_valid) begin
                    hold   <= sym_data;
                    bitcnt <= 2'(SBITS - 1);
                end
                ST_SHIFT: begin
                    // new bits enter at cell 0, so the oldest symbol drifts to CELLS-1
                    shadow <= {shadow[W-2:0], hold[bitcnt]};
                    bitcnt <= bitcnt - 2'd1;
                    if (bitcnt == 2'd0) symcnt <= symcnt + CW'(1);
                end
                ST_APPLY: begin
                    active <= shadow;
                    symcnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign cbitout = shadow[W-1];

    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        flags_t f;
        ycconfig_decode u_dec (
            .code  (active[SBITS*i +: SBITS]),
            .flags (f)
        );
        assign empty[i]   = f[F_EMPTY];
        assign hblock[i]  = f[F_HBLOCK];
        assign hbypass[i] = f[F_HBYPASS];
        assign hmatch0[i] = f[F_HMATCH0];
        assign hmatch1[i] = f[F_HMATCH1];
        assign vblock[i]  = f[F_VBLOCK];
        assign vbypass[i] = f[F_VBYPASS];
        assign vmatch0[i] = f[F_VMATCH0];
        assign vmatch1[i] = f[F_VMATCH1];
    end

endmodule

// File: tb/tb_ycconfig_row.sv
// Directed bench for ycconfig_row: two rows, the second fed from the first's cbitout.
module tb_ycconfig_row;

    localparam int CELLS = 8;

    logic       confclk = 1'b0;
    logic       reset   = 1'b1;
    logic       va = 1'b0, vb = 1'b0;
    logic [2:0] da = '0, db = '0;

    logic rdya, busya, donea, cbita;
    logic rdyb, busyb, doneb, cbitb;
    logic [CELLS-1:0] empa, hbla, hbpa, hm0a, hm1a, vbla, vbpa, vm0a, vm1a;
    logic [CELLS-1:0] empb, hblb, hbpb, hm0b, hm1b, vblb, vbpb, vm0b, vm1b;

    ycconfig_row #(.CELLS(CELLS)) u_a (
        .confclk(confclk), .reset(reset), .sym_valid(va), .sym_data(da),
        .sym_ready(rdya), .busy(busya), .done(donea), .cbitout(cbita),
        .empty(empa), .hblock(hbla), .hbypass(hbpa), .hmatch0(hm0a), .hmatch1(hm1a),
        .vblock(vbla), .vbypass(vbpa), .vmatch0(vm0a), .vmatch1(vm1a)
    );

    ycconfig_row #(.CELLS(CELLS)) u_b (
        .confclk(confclk), .reset(reset), .sym_valid(vb), .sym_data(db),
        .sym_ready(rdyb), .busy(busyb), .done(doneb), .cbitout(cbitb),
        .empty(empb), .hblock(hblb), .hbypass(hbpb), .hmatch0(hm0b), .hmatch1(hm1b),
        .vblock(vblb), .vbypass(vbpb), .vmatch0(vm0b), .vmatch1(vm1b)
    );

    always #5 confclk = ~confclk;

    int cyc = 0;
    always @(posedge confclk) cyc <= cyc + 1;

    // row-A observers, sampled mid-cycle
    int ndone_a = 0;
    int done_cyc = 0;
    int acc_q[$];
    bit cbit_q[$];
    always @(negedge confclk) begin
        if (donea) begin ndone_a++; done_cyc = cyc; end
        if (va && rdya) acc_q.push_back(cyc);
        if (busya && !donea) cbit_q.push_back(cbita);
    end

    int ntot = 0, npass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge confclk); #1;
    endtask

    task automatic push(input bit b, input logic [2:0] s);
        int n = 0;
        while (((b ? rdyb : rdya) !== 1'b1) && n < 40) begin tick(); n++; end
        if (n >= 40) chk("push_wait", n, 39);
        if (b) begin vb = 1'b1; db = s; end
        else   begin va = 1'b1; da = s; end
        tick();
        va = 1'b0; vb = 1'b0;
    endtask

    // row[23:21] is pushed first and so lands in cell 7
    task automatic pushrow(input bit b, input logic [23:0] row, input int first, input int last);
        for (int k = first; k <= last; k++) push(b, row[23-3*k -: 3]);
    endtask

    // returns in the APPLY cycle, before the commit edge
    task automatic wait_done(input bit b);
        int n = 0;
        while (((b ? doneb : donea) !== 1'b1) && n < 40) begin tick(); n++; end
        if (n >= 40) chk("done_wait", n, 39);
    endtask

    localparam logic [23:0] ROW2  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    localparam logic [23:0] PLUS8 = {8{3'b001}};
    localparam logic [23:0] N8    = {8{3'b111}};
    localparam logic [23:0] ZERO8 = {8{3'b101}};

    initial begin
        int a0, q0, nd, n, k, gaps;
        logic [23:0] rowb, bits;
        logic [2:0]  pat;

        // 1: reset state
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("rst_empty", empa, 8'hFF);
        chk("rst_hblock", hbla, 8'hFF);
        chk("rst_vblock", vbla, 8'hFF);
        chk("rst_others", hbpa | hm0a | hm1a | vbpa | vm0a | vm1a, 8'h00);
        chk("rst_ready", rdya, 1'b1);
        chk("rst_busy", busya, 1'b0);
        chk("rst_cbit", cbita, 1'b0);
        chk("rst_nodone", ndone_a, 0);

        // 2: one row of every symbol
        a0 = acc_q.size();
        pushrow(0, ROW2, 0, 7);
        wait_done(0);
        chk("t2_precommit_empty", empa, 8'hFF);
        tick();
        chk("t2_ndone", ndone_a, 1);
        // accept cycle counts as cycle 1, APPLY cycle as cycle 33
        chk("t2_done_lat", done_cyc - acc_q[a0] + 1, 33);
        chk("t2_empty", empa, 8'b1000_0000);
        chk("t2_hblock", hbla, 8'b1001_0000);
        chk("t2_vblock", vbla, 8'b1010_0000);
        chk("t2_hbypass", hbpa, 8'b0110_0000);
        chk("t2_vmatch1", vm1a, 8'b0000_1001);
        chk("t2_hmatch0", hm0a, 8'b0000_0101);

        // 6 + 4a: load all '+', capturing the previous row from cbitout
        q0 = cbit_q.size();
        pushrow(0, PLUS8, 0, 7);
        wait_done(0);
        tick();
        chk("t4_plus_hbyp", hbpa, 8'hFF);
        chk("t4_plus_vbyp", vbpa, 8'hFF);
        chk("t6_nbits", cbit_q.size() - q0, 24);
        rowb = '0;
        for (int j = 0; j < 24; j++) rowb[23-j] = cbit_q[q0+j];
        pushrow(1, rowb, 0, 7);
        wait_done(1);
        tick();
        chk("t6_b_empty", empb, 8'b1000_0000);
        chk("t6_b_hbypass", hbpb, 8'b0110_0000);
        chk("t6_b_vmatch1", vm1b, 8'b0000_1001);
        chk("t6_b_hmatch0", hm0b, 8'b0000_0101);

        // 4b: all 'N' over all '+'; active holds until the commit edge
        q0 = cbit_q.size();
        pushrow(0, N8, 0, 3);
        chk("t4_mid_hbyp", hbpa, 8'hFF);
        pushrow(0, N8, 4, 7);
        wait_done(0);
        chk("t4_pre_hbyp", hbpa, 8'hFF);
        chk("t4_pre_hm0", hm0a, 8'h00);
        tick();
        chk("t4_post_hm0", hm0a, 8'hFF);
        chk("t4_post_vm1", vm1a, 8'hFF);
        chk("t4_post_hbyp", hbpa, 8'h00);
        chk("t4_nbits", cbit_q.size() - q0, 24);
        bits = '0;
        for (int j = 0; j < 24 && q0 + j < cbit_q.size(); j++) bits[23-j] = cbit_q[q0+j];
        chk("t4_cbit_seq", bits, PLUS8);

        // 3: valid held high, data scrambled while not ready
        a0 = acc_q.size();
        va = 1'b1; k = 0; n = 0;
        while (k < 8 && n < 60) begin
            if (rdya) begin
                pat = k[0] ? 3'd3 : 3'd4;
                da = pat; k++;
            end else da = 3'($urandom);
            tick(); n++;
        end
        va = 1'b0;
        wait_done(0);
        tick();
        chk("t3_naccept", acc_q.size() - a0, 8);
        gaps = 0;
        for (int j = a0 + 1; j < acc_q.size(); j++) if (acc_q[j] - acc_q[j-1] == 4) gaps++;
        chk("t3_gap4", gaps, 7);
        chk("t3_hmatch1", hm1a, 8'b1010_1010);
        chk("t3_hblock", hbla, 8'b0101_0101);
        chk("t3_vbypass", vbpa, 8'b0101_0101);
        chk("t3_empty", empa, 8'h00);

        // 5: reset mid-SHIFT after 5 symbols
        pushrow(0, {8{3'd6}}, 0, 4);
        chk("t5_inshift", busya, 1'b1);
        reset = 1'b1;
        #1;
        chk("t5_rst_empty", empa, 8'hFF);
        chk("t5_rst_vblock", vbla, 8'hFF);
        chk("t5_rst_hm1", hm1a, 8'h00);
        chk("t5_rst_ready", rdya, 1'b1);
        chk("t5_rst_busy", busya, 1'b0);
        tick();
        reset = 1'b0;
        nd = ndone_a;
        pushrow(0, ZERO8, 0, 6);
        repeat (6) tick();
        chk("t5_nodone7", ndone_a - nd, 0);
        chk("t5_still_space", empa, 8'hFF);
        pushrow(0, ZERO8, 7, 7);
        wait_done(0);
        tick();
        chk("t5_done8", ndone_a - nd, 1);
        chk("t5_hm0", hm0a, 8'hFF);
        chk("t5_vm0", vm0a, 8'hFF);
        chk("t5_empty", empa, 8'h00);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
